// File: rtl/clear_pkg.sv
// Shared types and default widths for the rectangle-fill engine.
package clear_pkg;

    localparam int DEF_COORD_W = 32;
    localparam int DEF_COLOR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

endpackage

// File: rtl/clear_if.sv
// Request/pixel-stream bundle between a requester (master) and the fill engine (slave).
interface clear_if
    import clear_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int COLOR_W = DEF_COLOR_W
);

    logic               start;
    logic               done;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymax;
    logic               pixel_valid;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [COLOR_W-1:0] pixel_color;

    modport master (
        output start, color, xmin, ymin, xmax, ymax,
        input  done, pixel_valid, pixel_x, pixel_y, pixel_color
    );

    modport slave (
        input  start, color, xmin, ymin, xmax, ymax,
        output done, pixel_valid, pixel_x, pixel_y, pixel_color
    );

endinterface

// File: rtl/rect_scanner.sv
// Raster-order 2-D position counter over an inclusive rectangle, with a last-pixel flag.
module rect_scanner
    import clear_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] ymin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymax,
    output logic [COORD_W-1:0] nxt_x,
    output logic [COORD_W-1:0] nxt_y,
    output logic               last
);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] xmin_q;
    logic [COORD_W-1:0] xmax_q;
    logic [COORD_W-1:0] ymax_q;
    logic               row_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else if (load) begin
            x      <= xmin;
            y      <= ymin;
            xmin_q <= xmin;
            xmax_q <= xmax;
            ymax_q <= ymax;
        end else if (step) begin
            x <= nxt_x;
            y <= nxt_y;
        end
    end

    // Equality compares only: the increments are never used once last is set,
    // so all-ones bounds cannot wrap.
    always_comb begin
        row_end = (x == xmax_q);
        last    = row_end && (y == ymax_q);
        nxt_x   = row_end ? xmin_q : x + COORD_W'(1);
        nxt_y   = row_end ? y + COORD_W'(1) : y;
    end

endmodule

// File: rtl/clear_unit.sv
// Rectangle-fill engine: one (x, y, color) pixel write per clock over an inclusive
// rectangle in raster order, followed by a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last pixel
// RUN   | emitting one pixel per cycle
// FIN   | done pulse, then back to IDLE
module clear_unit
    import clear_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input logic  clk,
    input logic  rst,
    clear_if.slave bus
);

    state_t             state;
    logic               empty;
    logic               load;
    logic               step;
    logic               last;
    logic [COORD_W-1:0] nxt_x;
    logic [COORD_W-1:0] nxt_y;

    always_comb begin
        empty = (bus.xmin > bus.xmax) || (bus.ymin > bus.ymax);
        load  = (state == IDLE) && bus.start && !empty;
        step  = (state == RUN) && !last;
    end

    rect_scanner #(
        .COORD_W (COORD_W)
    ) u_scanner (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .xmin  (bus.xmin),
        .ymin  (bus.ymin),
        .xmax  (bus.xmax),
        .ymax  (bus.ymax),
        .nxt_x (nxt_x),
        .nxt_y (nxt_y),
        .last  (last)
    );

    // Pixel outputs are loaded straight from the request so the first pixel
    // appears the cycle after start; the scanner supplies every later one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.done        <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
            bus.pixel_color <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (empty) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state           <= RUN;
                            bus.pixel_valid <= 1'b1;
                            bus.pixel_x     <= bus.xmin;
                            bus.pixel_y     <= bus.ymin;
                            bus.pixel_color <= bus.color;
                        end
                    end
                end
                RUN: begin
                    if (last) begin
                        state           <= FIN;
                        bus.pixel_valid <= 1'b0;
                        bus.done        <= 1'b1;
                    end else begin
                        bus.pixel_x <= nxt_x;
                        bus.pixel_y <= nxt_y;
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    bus.done        <= 1'b0;
                    bus.pixel_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clear_unit.sv
// Bench for clear_unit: directed and random rectangles against a nested-loop pixel model.
module tb_clear_unit;
    import clear_pkg::*;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } pix_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clear_if bus ();

    clear_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    pix_t        exp_q[$];
    logic [31:0] hold_x, hold_y, hold_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input logic [31:0] xmin, input logic [31:0] ymin,
                               input logic [31:0] xmax, input logic [31:0] ymax);
        exp_q.delete();
        for (longint y = ymin; y <= longint'(ymax); y++)
            for (longint x = xmin; x <= longint'(xmax); x++)
                exp_q.push_back('{32'(x), 32'(y)});
    endtask

    task automatic set_req(input logic [31:0] xmin, input logic [31:0] ymin,
                           input logic [31:0] xmax, input logic [31:0] ymax,
                           input logic [31:0] col);
        bus.xmin  = xmin;
        bus.ymin  = ymin;
        bus.xmax  = xmax;
        bus.ymax  = ymax;
        bus.color = col;
        bus.start = 1'b1;
        build_model(xmin, ymin, xmax, ymax);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic run_rect(input logic [31:0] xmin, input logic [31:0] ymin,
                            input logic [31:0] xmax, input logic [31:0] ymax,
                            input logic [31:0] col, input bit disturb, input bit b2b);
        set_req(xmin, ymin, xmax, ymax, col);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
            if (disturb) begin
                bus.xmin  = $urandom;
                bus.ymin  = $urandom;
                bus.xmax  = $urandom;
                bus.ymax  = $urandom;
                bus.color = $urandom;
            end
            check($sformatf("valid[%0d]", k), bus.pixel_valid, 1);
            check($sformatf("x[%0d]", k), bus.pixel_x, exp_q[k].x);
            check($sformatf("y[%0d]", k), bus.pixel_y, exp_q[k].y);
            check($sformatf("color[%0d]", k), bus.pixel_color, col);
            check($sformatf("early_done[%0d]", k), bus.done, 0);
        end
        if (exp_q.size() > 0) begin
            hold_x = exp_q[exp_q.size()-1].x;
            hold_y = exp_q[exp_q.size()-1].y;
            hold_c = col;
        end
        @(negedge clk);
        bus.start = b2b;
        check("done", bus.done, 1);
        check("done_valid", bus.pixel_valid, 0);
        check("hold_x", bus.pixel_x, hold_x);
        check("hold_y", bus.pixel_y, hold_y);
        check("hold_color", bus.pixel_color, hold_c);
        @(negedge clk);
        check("done_once", bus.done, 0);
        check("idle_valid", bus.pixel_valid, 0);
        if (!b2b) bus.start = 1'b0;
    endtask

    initial begin
        logic [31:0] rx0, ry0, rx1, ry1;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.xmin  = '0;
        bus.ymin  = '0;
        bus.xmax  = '0;
        bus.ymax  = '0;
        bus.color = '0;
        hold_x    = '0;
        hold_y    = '0;
        hold_c    = '0;
        #1;
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.pixel_valid, 0);
        check("rst_x", bus.pixel_x, 0);
        check("rst_y", bus.pixel_y, 0);
        check("rst_color", bus.pixel_color, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_rect(32'd0, 32'd0, 32'd3, 32'd2, 32'hA5A5A5A5, 1'b0, 1'b0);
        run_rect(32'd5, 32'd7, 32'd5, 32'd7, $urandom, 1'b0, 1'b0);
        run_rect(32'd4, 32'd0, 32'd3, 32'd0, 32'h11111111, 1'b0, 1'b0);
        run_rect(32'd0, 32'd9, 32'd2, 32'd8, 32'h22222222, 1'b0, 1'b0);
        run_rect(32'd0, 32'd0, 32'd3, 32'd2, 32'h12345678, 1'b1, 1'b0);
        run_rect(32'd1, 32'd1, 32'd2, 32'd1, 32'hCAFEF00D, 1'b0, 1'b1);
        run_rect(32'd0, 32'd0, 32'd1, 32'd1, 32'h0BADBEEF, 1'b0, 1'b0);

        // Reset in the middle of a fill.
        set_req(32'd0, 32'd0, 32'd3, 32'd2, 32'h5A5A5A5A);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("pre_rst_x[%0d]", k), bus.pixel_x, exp_q[k].x);
            check($sformatf("pre_rst_y[%0d]", k), bus.pixel_y, exp_q[k].y);
        end
        #2 rst = 1'b1;
        #1;
        check("abort_done", bus.done, 0);
        check("abort_valid", bus.pixel_valid, 0);
        check("abort_x", bus.pixel_x, 0);
        check("abort_y", bus.pixel_y, 0);
        check("abort_color", bus.pixel_color, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_x = '0;
        hold_y = '0;
        hold_c = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_done[%0d]", k), bus.done, 0);
            check($sformatf("post_rst_valid[%0d]", k), bus.pixel_valid, 0);
        end
        run_rect(32'd0, 32'd0, 32'd1, 32'd1, 32'h77777777, 1'b0, 1'b0);

        run_rect(32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd1, 32'h00C0FFEE, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) rx0 = 32'hFFFFFFFF - $urandom_range(0, 3);
            else rx0 = $urandom_range(0, 500);
            ry0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 2)
                                              : $urandom_range(0, 500);
            rx1 = rx0 + $urandom_range(0, 3);
            ry1 = ry0 + $urandom_range(0, 3);
            if (rx1 < rx0) rx1 = 32'hFFFFFFFF;
            if (ry1 < ry0) ry1 = 32'hFFFFFFFF;
            if ($urandom_range(0, 4) == 0) begin
                rx0 = 32'd10;
                rx1 = $urandom_range(0, 9);
            end
            run_rect(rx0, ry0, rx1, ry1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
